// File: rtl/fir_pkg.sv
// +--------------------------------------------------------------------+
// | fir_pkg: widths, types and output scaling for the 10-tap FIR.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package fir_pkg;

  localparam int NTAPS = 10;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int FRAC  = 15;
  localparam int PW    = DW + CW;
  // Guard bits make the sum of NTAPS full-scale products impossible to overflow.
  localparam int ACCW  = DW + CW + $clog2(NTAPS);

  typedef logic signed [DW-1:0]   sample_t;
  typedef logic signed [CW-1:0]   coeff_t;
  typedef logic signed [PW-1:0]   prod_t;
  typedef logic signed [ACCW-1:0] acc_t;

  localparam acc_t    C_ACC_MAX = acc_t'((2 ** (DW - 1)) - 1);
  localparam acc_t    C_ACC_MIN = acc_t'(-(2 ** (DW - 1)));
  localparam sample_t C_OUT_MAX = {1'b0, {(DW - 1){1'b1}}};
  localparam sample_t C_OUT_MIN = {1'b1, {(DW - 1){1'b0}}};

  // Arithmetic shift floors toward -infinity; out-of-range results clamp.
  function automatic sample_t sat_shift(input acc_t i_acc);
    acc_t w_shifted;
    sample_t w_res;
    w_shifted = i_acc >>> FRAC;
    if (w_shifted > C_ACC_MAX)
      w_res = C_OUT_MAX;
    else if (w_shifted < C_ACC_MIN)
      w_res = C_OUT_MIN;
    else
      w_res = w_shifted[DW-1:0];
    return w_res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_tap.sv
// +--------------------------------------------------------------------+
// | fir_tap: one delay-line register plus the product of its input.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module fir_tap
  import fir_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  sample_t i_din,
  input  coeff_t  i_coeff,
  output sample_t o_q,
  output prod_t   o_prod
);

  sample_t r_x;

  always_ff @(posedge clock) begin
    if (!reset)
      r_x <= '0;
    else
      r_x <= i_din;
  end

  assign o_q    = r_x;
  // The tap weights the sample entering it, so tap 0 sees xin directly.
  assign o_prod = prod_t'(i_coeff) * prod_t'(i_din);

endmodule

`default_nettype wire

// File: rtl/fir_filter.sv
// +--------------------------------------------------------------------+
// | fir_filter: direct-form FIR, one sample per clock, saturated out.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module fir_filter
  import fir_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  sample_t xin,
  input  coeff_t  taps [NTAPS-1:0],
  output sample_t y
);

  sample_t w_s    [0:NTAPS];
  prod_t   w_prod [NTAPS-1:0];
  acc_t    w_acc;
  sample_t r_y;

  assign w_s[0] = xin;

  generate
    for (genvar g = 0; g < NTAPS; g++) begin : g_tap
      fir_tap u_tap (
        .clock   (clock),
        .reset   (reset),
        .i_din   (w_s[g]),
        .i_coeff (taps[g]),
        .o_q     (w_s[g+1]),
        .o_prod  (w_prod[g])
      );
    end
  endgenerate

  always_comb begin
    w_acc = '0;
    for (int j = 0; j < NTAPS; j++)
      w_acc = w_acc + acc_t'(w_prod[j]);
  end

  always_ff @(posedge clock) begin
    if (!reset)
      r_y <= '0;
    else
      r_y <= sat_shift(w_acc);
  end

  assign y = r_y;

endmodule

`default_nettype wire

// File: tb/tb_fir_filter.sv
// +--------------------------------------------------------------------+
// | tb_fir_filter: directed checks of reset, impulse, step, saturation.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fir_filter;
  import fir_pkg::*;

  logic    clock;
  logic    reset;
  sample_t xin;
  coeff_t  taps [NTAPS-1:0];
  sample_t y;

  int n_cmp;
  int n_fail;

  fir_filter dut (
    .clock (clock),
    .reset (reset),
    .xin   (xin),
    .taps  (taps),
    .y     (y)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] exp);
    n_cmp++;
    assert (y === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, y, exp);
    end
  endtask

  task automatic load_lowpass();
    logic [15:0] c [NTAPS];
    c = '{16'h0F85, 16'h079E, 16'h08D8, 16'h09C0, 16'h0A3C,
          16'h0A3C, 16'h09C0, 16'h08D8, 16'h079E, 16'h0F85};
    for (int j = 0; j < NTAPS; j++) taps[j] = c[j];
  endtask

  logic [15:0] imp_exp  [NTAPS];
  logic [15:0] step_exp [NTAPS];

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    imp_exp  = '{16'h0F84, 16'h079D, 16'h08D7, 16'h09BF, 16'h0A3B,
                 16'h0A3B, 16'h09BF, 16'h08D7, 16'h079D, 16'h0F84};
    step_exp = '{16'd1986, 16'd2961, 16'd4093, 16'd5341, 16'd6651,
                 16'd7961, 16'd9209, 16'd10341, 16'd11316, 16'd13303};

    // Reset held with live input must keep output at zero.
    reset = 1'b0;
    xin   = 16'h1234;
    load_lowpass();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", 16'h0000);
    end
    reset = 1'b1;
    xin   = 16'h0000;
    tick();
    check("reset_release", 16'h0000);

    // Impulse response reproduces each coefficient minus one.
    xin = 16'h7FFF;
    tick();
    check("impulse_0", imp_exp[0]);
    xin = 16'h0000;
    for (int i = 1; i < NTAPS; i++) begin
      tick();
      check("impulse_n", imp_exp[i]);
    end
    tick();
    check("impulse_tail", 16'h0000);

    // Step response ramps and settles.
    xin = 16'h4000;
    for (int i = 0; i < NTAPS; i++) begin
      tick();
      check("step_ramp", step_exp[i]);
    end
    tick();
    check("step_settled_a", 16'h33F7);
    tick();
    check("step_settled_b", 16'h33F7);

    // One-edge reset mid-stream discards the history.
    reset = 1'b0;
    tick();
    check("midreset", 16'h0000);
    reset = 1'b1;
    for (int i = 0; i < NTAPS; i++) begin
      tick();
      check("midreset_ramp", step_exp[i]);
    end

    // Negative product floors to -1 rather than 0.
    for (int j = 0; j < NTAPS; j++) taps[j] = 16'h0000;
    taps[0] = 16'h0F85;
    xin = 16'hFFFF;
    tick();
    check("neg_trunc", 16'hFFFF);
    xin = 16'h0000;
    tick();
    check("neg_trunc_next", 16'h0000);

    // Positive and negative saturation.
    for (int j = 0; j < NTAPS; j++) taps[j] = 16'h7FFF;
    xin = 16'h7FFF;
    for (int i = 0; i < 3; i++) tick();
    check("sat_pos_a", 16'h7FFF);
    for (int i = 0; i < NTAPS; i++) tick();
    check("sat_pos_full", 16'h7FFF);
    xin = 16'h8000;
    for (int i = 0; i < NTAPS; i++) tick();
    check("sat_neg_a", 16'h8000);
    tick();
    check("sat_neg_b", 16'h8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fir_filter.md
Name:
fir_filter

Overview:
- Direct-form 10-tap FIR filter, one new sample accepted per clock, no handshake.
- Input samples and coefficients are signed 16-bit Q1.15; output is signed 16-bit Q1.15.
- Used as a streaming DSP datapath block.
- Coefficients come from an external array port, so the filter is reprogrammable without resynthesis.

Parameters:
- NTAPS, 10, number of taps and delay-line depth.
- DW, 16, sample and output width, signed two's complement.
- CW, 16, coefficient width, signed two's complement.
- FRAC, 15, fractional bits of each coefficient; product shift amount.

Ports:
- clock  in  1  rising-edge system clock.
- reset  in  1  synchronous, active-low reset.
- xin  in  DW  input sample, captured on every rising edge while not in reset.
- taps  in  CW x NTAPS (unpacked array [NTAPS-1:0])  coefficients; taps[0] multiplies the newest sample.
- y  out  DW  filtered output, registered.

Behaviour:
- One clock and one synchronous, active-low reset; reset is sampled only on rising clock edges.
- Reset (reset==0 at a rising edge):
  - all NTAPS delay-line registers clear to 0;
  - y clears to 0;
  - taps and xin are ignored.
- Normal edge k (reset==1):
  - delay line shifts: x[0]<=xin, x[j]<=x[j-1];
  - y <= sat(( sum_{j=0..NTAPS-1} taps[j]*s[j] ) >>> FRAC), where s[0]=xin and s[j]=x[j-1] (delay-line contents before the shift).
- Latency: y after edge k reflects xin sampled at edge k. This is one registered stage, no internal pipeline.
- Throughput: one sample per clock, continuously. There is no valid/ready handshake and no stall.
- Taps are read combinationally every cycle. A coefficient change takes effect at the next edge, applied to all stored samples.
- Arithmetic:
  - each product is DW+CW = 32 bits signed;
  - the accumulator is DW+CW+$clog2(NTAPS) = 36 bits signed, so internal overflow is impossible;
  - scaling is an arithmetic right shift by FRAC with truncation toward -infinity and no rounding.
- Output saturation: if the shifted result is greater than 32767, y=16'h7FFF; if it is less than -32768, y=16'h8000. There is no wrap-around.
- Reset mid-stream: history is discarded. Following outputs are computed as if all prior samples were 0.
- Startup: the first NTAPS-1 outputs after reset contain only a partial history, with the missing samples taken as 0.
- No X propagation: every register has a defined reset value.

Decomposition:
- Package fir_pkg:
  - NTAPS, DW, CW, FRAC defaults;
  - ACCW = DW+CW+$clog2(NTAPS);
  - typedefs sample_t (logic signed [DW-1:0]), coeff_t, acc_t;
  - function sat_shift(acc_t) -> sample_t.
- One natural sub-module: fir_tap. It holds one delay register plus its signed multiply, is instantiated NTAPS times in a generate loop, and its products feed an adder tree in fir_filter.

Test Plan:
- Reset: hold reset=0 for 3 cycles with xin=16'h1234 and any taps, then release. Require y=0 during reset and on the first edge after release with xin=0.
- Impulse, taps={F85,79E,8D8,9C0,A3C,A3C,9C0,8D8,79E,F85}: xin=16'h7FFF for one edge, then 0. Require y for 10 consecutive edges = F84,79D,8D7,9BF,A3B,A3B,9BF,8D7,79D,F84 (each taps[j]-1), then 0.
- Step, same taps: xin=16'h4000 held. Require y to ramp and settle at 13303 (16'h33F7) from the 10th edge onward.
- Negative truncation: taps[0]=16'h0F85, all others 0; xin=16'hFFFF for one edge. Require y=16'hFFFF (-1), then 0 on the next edge.
- Saturation: all taps=16'h7FFF. xin=16'h7FFF held must give y=16'h7FFF once the sum exceeds range. xin=16'h8000 held must give y=16'h8000.
- Mid-stream reset: during the step test, assert reset=0 for one edge. Require y=0 at that edge and re-ramp from zero history afterwards.
